// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched
//   Serialises first-time toggle-coverage hits from NUM_PTS cover points into a
//   single valid/ready stream of global cover indices. Each point is reported at
//   most once per reset. Queued points drain one per cycle in round-robin order.
//
// Ports
//   clock         sole clock, all state updates on posedge
//   reset         synchronous, active-high; drops queued and in-flight hits
//   valid         per-point toggle hit this cycle (ignored during reset)
//   out_valid     out_index holds a first-time hit
//   out_ready     sink accepts out_index when out_valid && out_ready
//   out_index     global cover index (COVER_INDEX + local bit)
//   pending_cnt   number of points queued but not yet loaded to the output
//   reported_cnt  number of points loaded to the output since reset
//   all_covered   every point reported and the last one accepted

module cover_toggle_sched #(
    parameter int unsigned     NUM_PTS     = 52,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int unsigned     IDX_W       = 64,
    localparam int unsigned    CNT_W       = $clog2(NUM_PTS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_PTS-1:0] valid,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [CNT_W-1:0]   pending_cnt,
    output logic [CNT_W-1:0]   reported_cnt,
    output logic               all_covered
);

    localparam int unsigned PTR_W = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;

    logic [NUM_PTS-1:0] seen, seen_nxt;
    logic [NUM_PTS-1:0] pending, pending_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic               out_valid_nxt;
    logic [IDX_W-1:0]   out_index_nxt;
    logic [CNT_W-1:0]   reported_cnt_nxt;

    logic [PTR_W-1:0]   sel_hi, sel_any, sel;
    logic               found_hi, found_any;
    logic               load, take;
    logic [NUM_PTS-1:0] load_mask;

    // Round-robin pick: lowest pending bit at or above ptr, else lowest overall.
    // Scanning downward leaves the lowest qualifying index in each result.
    always_comb begin
        sel_hi    = '0;
        sel_any   = '0;
        found_hi  = 1'b0;
        found_any = 1'b0;
        for (int i = int'(NUM_PTS) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_any   = PTR_W'(i);
                found_any = 1'b1;
                if (PTR_W'(i) >= ptr) begin
                    sel_hi   = PTR_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        sel = found_hi ? sel_hi : sel_any;
    end

    // Next-state: capture new hits, load the output register when it frees up.
    always_comb begin
        load             = !out_valid || out_ready;
        take             = load && found_any;
        load_mask        = '0;
        ptr_nxt          = ptr;
        out_valid_nxt    = out_valid;
        out_index_nxt    = out_index;
        reported_cnt_nxt = reported_cnt;

        if (take) begin
            load_mask[sel]   = 1'b1;
            out_index_nxt    = IDX_W'(COVER_INDEX) + IDX_W'(sel);
            ptr_nxt          = (sel == PTR_W'(NUM_PTS - 1)) ? '0 : sel + PTR_W'(1);
            reported_cnt_nxt = reported_cnt + CNT_W'(1);
        end
        if (load) begin
            out_valid_nxt = found_any;
        end

        // A same-edge hit on the bit being loaded is already pending, so the
        // load mask clears it and seen blocks any later repeat.
        pending_nxt = (pending | (valid & ~seen & ~pending)) & ~load_mask;
        seen_nxt    = seen | load_mask;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            seen         <= '0;
            pending      <= '0;
            ptr          <= '0;
            out_valid    <= 1'b0;
            out_index    <= '0;
            reported_cnt <= '0;
        end else begin
            seen         <= seen_nxt;
            pending      <= pending_nxt;
            ptr          <= ptr_nxt;
            out_valid    <= out_valid_nxt;
            out_index    <= out_index_nxt;
            reported_cnt <= reported_cnt_nxt;
        end
    end

    // Queue occupancy, derived from registered state only.
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < int'(NUM_PTS); i++) begin
            pending_cnt = pending_cnt + CNT_W'(pending[i]);
        end
    end

    assign all_covered = (&seen) && !out_valid;

endmodule
